ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte, such as 0xED set-LEDs or 0xFF reset, from the FPGA to the keyboard.
- Sits beside the keyboard receive path on the same open-collector ps2_clk/ps2_data pair.
- Drives the lines through output-enable (pull-low) signals and samples them through a synchronizer.
- Asserts busy so the receive path ignores bus activity while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 5000, sys_clk cycles the clock line is held low before the request (100 us at 50 MHz); minimum 2.
TIMEOUT_CYCLES, 1000000, max sys_clk cycles between device clock falling edges before the transfer is aborted (20 ms at 50 MHz).
SYNC_STAGES, 2, flip-flop stages on ps2_clk_in and ps2_data_in; minimum 2.

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid && tx_ready at a sys_clk edge
tx_ready  out  1  high only in IDLE
ps2_clk_in  in  1  raw PS/2 clock line level
ps2_data_in  in  1  raw PS/2 data line level
ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
ps2_data_oe  out  1  1 = pull data line low, 0 = release
busy  out  1  high in every state except IDLE
tx_done  out  1  one-cycle pulse: byte sent and ACK received
tx_error  out  1  one-cycle pulse: missing ACK or timeout

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE; tx_ready=1, busy=0; ps2_clk_oe=0, ps2_data_oe=0; tx_done=0, tx_error=0.
  - Counters and the shift register clear; synchronizer stages load 1.
  - Reset mid-transfer releases both lines immediately, with no clock edge required.
- Falling edge detection: synchronized clock previous-sample=1 and current-sample=0. Latency is SYNC_STAGES+1 sys_clk cycles from the pin.
- Frame: {stop=1, parity, d7..d0}, LSB first.
  - Parity is odd: parity = ~^tx_data.
  - The start bit is data held low at the moment the clock line is released.
- State IDLE: tx_ready=1. On accept, latch tx_data and the parity bit; next state INHIBIT.
- State INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_data_oe is asserted on the last inhibit cycle.
  - Next state REQ.
- State REQ: ps2_clk_oe=0, ps2_data_oe=1 (start bit). Edge counter=0. Wait for a falling edge.
- State SHIFT, entered on the 1st falling edge:
  - On falling edges 1..8, drive data bit n-1: ps2_data_oe = ~bit.
  - On edge 9, drive parity.
  - On edge 10, release data (stop bit).
  - A 4-bit edge counter increments on each falling edge; it never wraps within a frame.
- State ACK:
  - Entered after edge 10.
  - On edge 11, sample synchronized data: 0 = ACK, 1 = NACK.
- State WAIT_IDLE:
  - After ACK, wait until synchronized clock=1 and data=1.
  - Then pulse tx_done and go to IDLE.
  - After NACK, pulse tx_error and go to IDLE.
- Timeout:
  - A cycle counter resets on every falling edge and on entry to REQ.
  - In REQ, SHIFT, ACK or WAIT_IDLE, if it reaches TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE.
- Simultaneous events: a timeout and a falling edge in the same cycle resolve as the edge, and the counter clears.
- tx_valid while busy is ignored, with no queuing; tx_data changes after accept have no effect.
- tx_done and tx_error are never high in the same cycle.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - NACK or timeout restarts the same latched byte from INHIBIT, up to 2 retries.
  - tx_error pulses only after the third failed attempt; tx_ready stays 0 throughout.
  - The retry counter clears on accept and on reset.
- Not defined: the first NACK or timeout pulses tx_error and returns to IDLE.

Test Plan:
Bench parameters for all scenarios: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200.
- Send 0xED; device model clocks at 40 sys_clk period and ACKs → clk_oe low for exactly 10 cycles; bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1; tx_done pulses once; tx_ready returns to 1.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Both end with tx_done.
- Device leaves data high on edge 11 (NACK) → tx_error pulse, no tx_done, both oe=0. With PS2_TX_RETRY_EN: 3 full frames observed, then a single tx_error.
- Device stops clocking after edge 4 → tx_error exactly 200 cycles after edge 4; lines released; tx_ready=1.
- Assert reset=0 during bit 5 → ps2_clk_oe=0, ps2_data_oe=0, busy=0 asynchronously. A following send of 0xFF completes normally.
- Pulse tx_valid with 0x55 while busy with 0xED → frame carries 0xED only; 0x55 is never sent.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over the open-collector ps2_clk/ps2_data pair.
// Optional feature macro PS2_TX_RETRY_EN: a NACKed or timed-out byte is retried up to two more times.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);
    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_DATA = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic [3:0]             edge_cnt_q, edge_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic                   clk_oe_q, clk_oe_d;
    logic                   data_oe_q, data_oe_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]             retry_q, retry_d;
    logic [7:0]             byte_q, byte_d;
`endif

    logic clk_s;
    logic data_s;
    logic fall;
    logic active;
    logic fail;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = clk_prev_q & ~clk_s;
    assign active = (state_q == S_REQ) || (state_q == S_SHIFT) ||
                    (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
        // Our own inhibit pulls the clock low; blank that so it never looks like a device edge in REQ.
        clk_prev_d  = (state_q == S_INHIBIT) ? 1'b0 : clk_s;
        inh_cnt_d   = inh_cnt_q;
        to_cnt_d    = to_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        shift_d     = shift_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        fail        = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
        byte_d      = byte_q;
`endif

        if (active) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                fail = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d   = 2'd0;
                    byte_d    = tx_data;
`endif
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b1;
                    to_cnt_d   = '0;
                    edge_cnt_d = 4'd0;
                    state_d    = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + IW'(1);
                    if (inh_cnt_q == INH_DATA) begin
                        data_oe_d = 1'b1;
                    end
                end
            end
            S_REQ, S_SHIFT: begin
                if (fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    data_oe_d  = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    state_d    = (edge_cnt_q == 4'd9) ? S_ACK : S_SHIFT;
                end
            end
            S_ACK: begin
                if (fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (!data_s) begin
                        state_d = S_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A completed handshake wins over a timeout landing in the same cycle.
        if (fail && !done_d) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d   = retry_q + 2'd1;
                shift_d   = {1'b1, ~^byte_q, byte_q};
                inh_cnt_d = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = S_INHIBIT;
            end else begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                error_d   = 1'b1;
                state_d   = S_IDLE;
            end
`else
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            error_d   = 1'b1;
            state_d   = S_IDLE;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            inh_cnt_q   <= '0;
            to_cnt_q    <= '0;
            edge_cnt_q  <= 4'd0;
            shift_q     <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= 2'd0;
            byte_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            inh_cnt_q   <= inh_cnt_d;
            to_cnt_q    <= to_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            shift_q     <= shift_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PS2_TX_RETRY_EN
            retry_q     <= retry_d;
            byte_q      <= byte_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a keyboard model clocks frames, a monitor checks every tx_done/tx_error.
// Covers ACK, NACK, timeout, async reset mid-frame and tx_valid while busy.
module tb_ps2_host_tx;
    localparam int INH  = 10;
    localparam int TO   = 200;
    localparam int SYNC = 2;

    localparam int KIND_DONE  = 0;
    localparam int KIND_ERROR = 1;
    localparam int KIND_NONE  = 2;

    logic       sysClk = 1'b0;
    logic       reset;
    logic [7:0] txData;
    logic       txValid;
    logic       devClk  = 1'b1;
    logic       devPull = 1'b0;
    logic       ps2ClkIn;
    logic       ps2DataIn;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;

    // Open-collector bus: either side pulling low wins.
    assign ps2ClkIn  = ~ps2_clk_oe & devClk;
    assign ps2DataIn = ~ps2_data_oe & ~devPull;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(SYNC)
    ) dut (
        .sys_clk    (sysClk),
        .reset      (reset),
        .tx_data    (txData),
        .tx_valid   (txValid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2ClkIn),
        .ps2_data_in(ps2DataIn),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        bit         isError;
        bit         chkFrame;
        logic [7:0] data;
    } exp_t;

    exp_t       sbQ[$];
    exp_t       expNow;
    int         total = 0;
    int         bad = 0;
    int         respCnt = 0;
    int         respBase = 0;
    int         frameCnt = 0;
    int         cyc = 0;
    int         edgeNum = 0;
    int         edge4Cyc = 0;
    int         errCyc = 0;
    int         inhRun = 0;
    int         inhLen = 0;
    logic [9:0] cap = '0;
    logic       startBit = 1'b1;

    always @(posedge sysClk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: measures inhibit length and checks each completion against the scoreboard.
    always @(negedge sysClk) begin
        if (ps2_clk_oe) begin
            inhRun++;
        end else if (inhRun != 0) begin
            inhLen = inhRun;
            inhRun = 0;
        end
        if (tx_done || tx_error) begin
            respCnt++;
            if (tx_error) errCyc = cyc;
            checkOutput("done_err_exclusive", {31'd0, tx_done & tx_error}, 0);
            checkOutput("resp_expected", {31'd0, sbQ.size() != 0}, 1);
            if (sbQ.size() != 0) begin
                expNow = sbQ.pop_front();
                checkOutput("resp_kind", {31'd0, tx_error}, {31'd0, expNow.isError});
                if (expNow.isError) begin
                    checkOutput("err_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                end
                if (expNow.chkFrame) begin
                    checkOutput("inhibit_len", inhLen, INH);
                    checkOutput("start_bit", {31'd0, startBit}, 0);
                    checkOutput("frame_data", {24'd0, cap[7:0]}, {24'd0, expNow.data});
                    checkOutput("frame_parity", {31'd0, cap[8]}, {31'd0, ~^expNow.data});
                    checkOutput("frame_stop", {31'd0, cap[9]}, 1);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input int kind, input bit chkFrame);
        exp_t e;
        int   n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge sysClk);
            n++;
        end
        @(negedge sysClk);
        respBase = respCnt;
        if (kind != KIND_NONE) begin
            e.isError  = (kind == KIND_ERROR);
            e.chkFrame = chkFrame;
            e.data     = d;
            sbQ.push_back(e);
        end
        txData  = d;
        txValid = 1'b1;
        @(negedge sysClk);
        txValid = 1'b0;
        txData  = ~d;
        checkOutput("accepted_busy", {31'd0, busy}, 1);
    endtask

    // Keyboard model: waits for the request, clocks at a 40-cycle period, samples data on rising edges.
    task automatic deviceFrame(input int nEdges, input bit ack);
        int n = 0;
        cap      = '0;
        startBit = 1'b1;
        edgeNum  = 0;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && n < 2000) begin
            @(negedge sysClk);
            n++;
        end
        if (n >= 2000) begin
            checkOutput("req_seen", {31'd0, busy && !ps2_clk_oe && ps2_data_oe}, 1);
            return;
        end
        repeat (15) @(negedge sysClk);
        startBit = ps2DataIn;
        for (int e = 1; e <= nEdges; e++) begin
            if (!busy) break;
            devClk  = 1'b0;
            edgeNum = e;
            if (e == 4) edge4Cyc = cyc;
            repeat (20) @(negedge sysClk);
            devClk = 1'b1;
            if (e <= 10) cap[e-1] = ps2DataIn;
            if (e == 11) devPull = 1'b0;
            repeat (10) @(negedge sysClk);
            if (e == 10 && ack) devPull = 1'b1;
            repeat (10) @(negedge sysClk);
        end
        devPull = 1'b0;
        devClk  = 1'b1;
        frameCnt++;
    endtask

    task automatic waitResponse(input int budget);
        int n = 0;
        while (respCnt == respBase && n < budget) begin
            @(negedge sysClk);
            n++;
        end
        checkOutput("resp_arrived", respCnt - respBase, 1);
        @(negedge sysClk);
        checkOutput("ready_after", {31'd0, tx_ready}, 1);
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int framesBefore;
        int n;
        reset   = 1'b0;
        txValid = 1'b0;
        txData  = 8'h00;
        repeat (3) @(negedge sysClk);
        checkOutput("rst_ready", {31'd0, tx_ready}, 1);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        checkOutput("rst_data_oe", {31'd0, ps2_data_oe}, 0);
        checkOutput("rst_done", {31'd0, tx_done}, 0);
        checkOutput("rst_error", {31'd0, tx_error}, 0);
        reset = 1'b1;
        repeat (3) @(negedge sysClk);

        $display("[TB] send 0xED with ACK");
        applyStimulus(8'hED, KIND_DONE, 1'b1);
        deviceFrame(11, 1'b1);
        waitResponse(500);

        $display("[TB] send 0x00 and 0x01");
        applyStimulus(8'h00, KIND_DONE, 1'b1);
        deviceFrame(11, 1'b1);
        waitResponse(500);
        applyStimulus(8'h01, KIND_DONE, 1'b1);
        deviceFrame(11, 1'b1);
        waitResponse(500);

        $display("[TB] send 0x3C with NACK");
        framesBefore = frameCnt;
        applyStimulus(8'h3C, KIND_ERROR, 1'b1);
`ifdef PS2_TX_RETRY_EN
        repeat (3) deviceFrame(11, 1'b0);
        waitResponse(500);
        checkOutput("nack_frames", frameCnt - framesBefore, 3);
`else
        deviceFrame(11, 1'b0);
        waitResponse(500);
        checkOutput("nack_frames", frameCnt - framesBefore, 1);
`endif

        $display("[TB] send 0x5A, device stops after edge 4");
        applyStimulus(8'h5A, KIND_ERROR, 1'b0);
        deviceFrame(4, 1'b1);
        waitResponse(3000);
`ifndef PS2_TX_RETRY_EN
        // Pin fall to detected edge is SYNC+1 cycles, then TIMEOUT cycles to the error pulse.
        checkOutput("timeout_latency", errCyc - edge4Cyc, SYNC + 1 + TO);
`endif

        $display("[TB] reset during bit 5 of 0xA5, then send 0xFF");
        applyStimulus(8'hA5, KIND_NONE, 1'b0);
        fork
            deviceFrame(11, 1'b1);
            begin
                n = 0;
                while (edgeNum < 5 && n < 2000) begin
                    @(negedge sysClk);
                    n++;
                end
                checkOutput("reached_bit5", {31'd0, edgeNum >= 5}, 1);
                repeat (5) @(negedge sysClk);
                checkOutput("bit5_driving", {31'd0, ps2_data_oe}, 1);
                #2 reset = 1'b0;
                #1;
                checkOutput("async_clk_oe", {31'd0, ps2_clk_oe}, 0);
                checkOutput("async_data_oe", {31'd0, ps2_data_oe}, 0);
                checkOutput("async_busy", {31'd0, busy}, 0);
                repeat (3) @(negedge sysClk);
                reset = 1'b1;
            end
        join
        applyStimulus(8'hFF, KIND_DONE, 1'b1);
        deviceFrame(11, 1'b1);
        waitResponse(500);

        $display("[TB] send 0xED, pulse 0x55 while busy");
        applyStimulus(8'hED, KIND_DONE, 1'b1);
        fork
            deviceFrame(11, 1'b1);
            begin
                repeat (100) @(negedge sysClk);
                txData  = 8'h55;
                txValid = 1'b1;
                @(negedge sysClk);
                txValid = 1'b0;
            end
        join
        waitResponse(500);
        repeat (100) @(negedge sysClk);
        checkOutput("no_second_accept", {31'd0, busy}, 0);

        repeat (20) @(negedge sysClk);
        checkOutput("sb_drained", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
